// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, 5..9 data bits (LSB/MSB first),
// optional odd/even parity, 1 or 2 stop bits, valid/ready input handshake.
module uart_tx_param #(
  parameter int unsigned CLK_FREQ  = 48000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam bit          HAS_PAR  = (PARITY == 1) || (PARITY == 2);
  localparam bit          ODD_PAR  = (PARITY == 1);
  localparam bit          MSB_1ST  = (MSB_FIRST != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     baud_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 baud_wrap;
  logic                 ser_bit;
  logic [DATA_BITS-1:0] shift_next;

  assign tx_ready  = (state_q == S_IDLE);
  assign txd       = txd_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

  assign baud_wrap  = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));
  assign ser_bit    = MSB_1ST ? shift_q[DATA_BITS-1] : shift_q[0];
  assign shift_next = MSB_1ST ? {shift_q[DATA_BITS-2:0], 1'b0}
                              : {1'b0, shift_q[DATA_BITS-1:1]};

  // Frame sequencer; txd only changes on a baud-counter wrap or on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) begin
        baud_cnt_q <= baud_wrap ? '0 : baud_cnt_q + CNT_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (tx_valid) begin
            shift_q    <= tx_data;
            par_q      <= (^tx_data) ^ ODD_PAR;
            state_q    <= S_START;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
            baud_cnt_q <= '0;
          end
        end
        S_START: begin
          if (baud_wrap) begin
            txd_q     <= ser_bit;
            shift_q   <= shift_next;
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_wrap) begin
            if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              if (HAS_PAR) begin
                state_q <= S_PARITY;
                txd_q   <= par_q;
              end else begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              txd_q     <= ser_bit;
              shift_q   <= shift_next;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (baud_wrap) begin
            state_q   <= S_STOP;
            txd_q     <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        S_STOP: begin
          if (baud_wrap) begin
            if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter and successor to the fixed 8-bit transmitter. Serialises one character per frame: start bit, 5–9 data bits (LSB- or MSB-first), optional odd or even parity, then 1 or 2 stop bits. Replaces the level-held start input with a valid/ready handshake and adds a frame-done pulse, so a FIFO or register-bank front end can drive it back-to-back.

Parameters:
CLK_FREQ, 48000, input clock frequency in Hz
BAUD, 9600, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer divide), must be >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; 1 or 2
MSB_FIRST, 0, 0 = data bit 0 sent first, 1 = data bit DATA_BITS-1 sent first

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
tx_data  in  DATA_BITS  character to send; sampled only on handshake
tx_valid  in  1  upstream has a character
tx_ready  out  1  block can accept a character; high only in IDLE
txd  out  1  serial line, idle high
tx_busy  out  1  high from the acceptance edge until the end of the last stop bit
tx_done  out  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (async): state=IDLE, txd=1, tx_busy=0, tx_done=0, all counters=0, shift register=0. tx_ready=1 once rst_n is high.
- Reset mid-frame: the frame is aborted immediately and txd goes to 1 asynchronously. Partial frames are never resumed.
- tx_ready is combinational: (state==IDLE). The handshake is tx_valid && tx_ready, sampled at a clk rising edge.
- At the handshake edge:
  - tx_data is latched into the shift register.
  - The parity bit is computed from the latched data. Even parity: XOR of the data bits. Odd parity: the inverse of that XOR.
  - state=START, txd<=0, tx_busy<=1, baud counter=0.
- Latency: txd falls on the same edge that accepts the character.
- Bit timing:
  - Every bit (start, data, parity, stop) lasts exactly BAUD_DIV clocks.
  - The baud counter runs 0..BAUD_DIV-1. It has width clog2(BAUD_DIV), with a minimum of 1.
  - txd changes only on the edge where the counter wraps to 0.
- States:
  - IDLE: txd=1. On handshake go to START.
  - START: txd=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: send DATA_BITS bits. Bit counter width is 4. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: send the parity bit for BAUD_DIV cycles, then go to STOP.
  - STOP: txd=1 for STOP_BITS*BAUD_DIV cycles, then go to IDLE.
- End of frame, on the edge that ends the last stop-bit period:
  - state goes to IDLE, tx_busy<=0, tx_done<=1 for exactly one cycle.
  - txd stays 1.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BAUD_DIV cycles, counted from the acceptance edge to the tx_done edge.
- Back-to-back: with tx_valid held high, the next character is accepted one cycle after tx_done. This gives exactly one extra idle clock of txd=1 between frames.
- Changes on tx_data or tx_valid during a frame are ignored; no second character is captured.
- The data bit order is fixed by MSB_FIRST and is not changed at run time.
- PARITY values other than 0/1/2 are treated as none.
- No glitches on txd: it is driven directly by a flop.

Test Plan:
- Defaults (BAUD_DIV=5, 8N1, LSB-first); tx_data=0xA5 pulsed valid for one cycle.
  - txd: 0 for 5 clk, then 1,0,1,0,0,1,0,1 at 5 clk each, then 1 for 5 clk.
  - tx_done pulses 50 clk after the acceptance edge; tx_busy is high for 50 clk.
- PARITY=2 with 0xA5 → parity bit 0. PARITY=1 with 0xA5 → parity bit 1. PARITY=1 with 0x07 → parity bit 0. Frame length is 55 clk in each case.
- DATA_BITS=7, MSB_FIRST=1, STOP_BITS=2, tx_data=7'h41.
  - Data bits on line: 1,0,0,0,0,0,1.
  - Stop high for 10 clk; total 50 clk.
- tx_valid held high for 3 characters 0x00, 0xFF, 0x55.
  - tx_ready is high for exactly 1 cycle after each tx_done.
  - Exactly 3 tx_done pulses, 51-clk spacing, no extra frame.
- Assert rst_n low at cycle 23 of a frame.
  - txd=1, tx_busy=0, tx_done=0 immediately.
  - After release: tx_ready=1; the next frame, 0x3C, is transmitted correctly from its start bit.
- Change tx_data to 0xFF mid-frame while sending 0x12.
  - Line carries 0x12 unchanged; tx_ready stays low until IDLE.
